softmax_row_buffer: RTL and testbench
=====================================

Name: softmax_row_buffer

Overview:
- Parametrised output stage for the softmax pipeline: accepts one full softmax result row (N elements, DATA_W bits each) per valid pulse.
- Serialises each row into an internal simple-dual-port row buffer holding up to ROWS rows.
- Streams completed rows back out oldest-first over a valid/ready port.
- Generalises the fixed 32-element, single-row flatten-and-probe path to configurable width, row length and row depth, adds backpressure and adds overflow reporting.

Parameters:
N, 32, elements per row (power of two, >=2)
DATA_W, 16, bits per element (unsigned Q0.DATA_W softmax value)
ROWS, 4, row slots in buffer (power of two, >=1)

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous active-high reset
i_valid  in  1  one-cycle pulse: i_row holds a complete softmax row
i_row  in  N*DATA_W  packed row; element k = i_row[k*DATA_W +: DATA_W]
o_busy  out  1  write FSM serialising a row
o_row_done  out  1  one-cycle pulse: row fully written to buffer
o_rows_stored  out  $clog2(ROWS+1)  completed rows held
o_overflow  out  1  sticky: an input row was dropped
i_rd_start  in  1  pulse: begin streaming oldest stored row
o_rd_valid  out  1  o_rd_data valid
i_rd_ready  in  1  consumer accepts element when o_rd_valid high
o_rd_data  out  DATA_W  element value
o_rd_idx  out  $clog2(N)  element index within row
o_rd_last  out  1  high with element N-1

Behaviour:
- Reset (async, i_rst high): all outputs 0; wr_ptr, rd_ptr, count, FSMs to IDLE.
- Reset does not clear buffer contents; they are don't-care after reset.
- Reset asserted mid-write or mid-read aborts the operation; a partial row is never counted.

Write FSM, states IDLE -> WRITE -> IDLE:
- In IDLE, i_valid with count<ROWS: register i_row into shadow register, idx=0, enter WRITE.
- o_busy is high from the next cycle.
- In WRITE: each cycle write element idx to address wr_ptr*N+idx, then idx++.
- On idx==N-1 write: return to IDLE, pulse o_row_done in the following cycle, wr_ptr++ (mod ROWS), count++.
- Latency: i_valid to o_row_done = N+1 cycles.
- i_valid while in WRITE, or while count==ROWS: row dropped, o_overflow set until reset, no other state change.
- i_valid in the same cycle as o_row_done (FSM already IDLE) is accepted.

Read FSM, states IDLE -> FETCH -> STREAM -> IDLE:
- i_rd_start in IDLE with count>0: enter FETCH, issue RAM read rd_ptr*N+0 (1-cycle synchronous RAM latency).
- i_rd_start with count==0 or FSM not IDLE is ignored.
- o_rd_valid rises exactly 2 cycles after the accepted i_rd_start.
- In STREAM, an element transfers when o_rd_valid && i_rd_ready.
- While i_rd_ready is low, o_rd_data, o_rd_idx and o_rd_last hold stable.
- With i_rd_ready held high: one element per cycle, no bubbles. The next address must be prefetched so throughput is 1/cycle; use a skid/output register as needed.
- o_rd_last = (o_rd_idx==N-1).
- Transfer of the last element: o_rd_valid low next cycle, rd_ptr++ (mod ROWS), count--, return to IDLE.

Count and buffer rules:
- Row write completion and last-element pop in the same cycle: count unchanged, both pointers advance.
- A slot is readable only after its o_row_done and writable only after its pop, so read/write address collision cannot occur.
- Pointers wrap ROWS-1 -> 0.
- count is never exceeded; the overflow check uses the registered count.
- Buffer is N*ROWS x DATA_W, read and write ports independent, inferred as block RAM.

Test Plan:
- Reset, then drive a single row with element k = 16'h0100+k, N=32: o_busy high for 32 cycles, o_row_done at cycle 33, o_rows_stored=1. Then pulse i_rd_start with i_rd_ready=1: o_rd_valid at +2, 32 consecutive beats with data 0x0100..0x011F, idx 0..31, o_rd_last on the 32nd beat, count returns to 0.
- Write 4 rows (row r, element k = r*256+k): count=4. Send a 5th i_valid: row dropped, o_overflow=1, count=4. Read all 4 rows: data comes back in order r=0..3, pointers wrap, count=0.
- Backpressure: during a row read, toggle i_rd_ready in a 1-of-3 pattern. Every element 0..31 arrives exactly once, in order, and outputs are stable while ready is low.
- i_valid pulsed again 10 cycles into a write: o_overflow set, first row intact on readback, o_row_done pulses only once.
- With count=ROWS-1, finish reading a row on the same cycle o_row_done fires: count stays ROWS-1 and both rows read back correctly.
- Assert i_rst mid-WRITE and mid-STREAM: all outputs 0 immediately, count=0. A subsequent write/read of a fresh row returns correct data.
- i_rd_start with count=0: no o_rd_valid for 10 cycles.

Source files
------------

// File: rtl/softmax_row_buffer_if.sv
// Handshake and data bundle for the softmax row buffer: row input, status and element stream.
// The buffer itself uses the slave modport; the producer/consumer side uses master.
interface softmax_row_buffer_if #(
  parameter int N      = 32,
  parameter int DATA_W = 16,
  parameter int ROWS   = 4
);
  localparam int IDX_W = $clog2(N);
  localparam int CNT_W = $clog2(ROWS + 1);

  logic                  i_valid;
  logic [N*DATA_W-1:0]   i_row;
  logic                  o_busy;
  logic                  o_row_done;
  logic [CNT_W-1:0]      o_rows_stored;
  logic                  o_overflow;
  logic                  i_rd_start;
  logic                  o_rd_valid;
  logic                  i_rd_ready;
  logic [DATA_W-1:0]     o_rd_data;
  logic [IDX_W-1:0]      o_rd_idx;
  logic                  o_rd_last;

  modport slave (
    input  i_valid, i_row, i_rd_start, i_rd_ready,
    output o_busy, o_row_done, o_rows_stored, o_overflow,
    output o_rd_valid, o_rd_data, o_rd_idx, o_rd_last
  );

  modport master (
    output i_valid, i_row, i_rd_start, i_rd_ready,
    input  o_busy, o_row_done, o_rows_stored, o_overflow,
    input  o_rd_valid, o_rd_data, o_rd_idx, o_rd_last
  );
endinterface

// File: rtl/softmax_row_buffer.sv
// Serialises N-element softmax rows into a ROWS-deep RAM and streams them out oldest-first; row_done N+1 cycles
// after i_valid, first element 2 cycles after i_rd_start, output held stable while i_rd_ready is low.
module softmax_row_buffer #(
  parameter int N      = 32,
  parameter int DATA_W = 16,
  parameter int ROWS   = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  softmax_row_buffer_if.slave bus
);
  localparam int IDX_W  = $clog2(N);
  localparam int PTR_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CNT_W  = $clog2(ROWS + 1);
  localparam int ADDR_W = $clog2(N * ROWS);
  localparam int DEPTH  = N * ROWS;

  typedef enum logic {WR_IDLE, WR_WRITE} wr_state_t;
  typedef enum logic [1:0] {RD_IDLE, RD_FETCH, RD_STREAM} rd_state_t;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] ram_q;

  wr_state_t           wr_state;
  logic [N*DATA_W-1:0] shadow;
  logic [IDX_W-1:0]    wr_idx;
  logic [PTR_W-1:0]    wr_ptr;
  logic                busy;
  logic                row_done;
  logic                overflow;

  rd_state_t           rd_state;
  logic [PTR_W-1:0]    rd_ptr;
  logic                rd_valid;
  logic                rd_last;
  logic [IDX_W-1:0]    rd_idx;
  logic [CNT_W-1:0]    count;

  logic                wr_en;
  logic                wr_fin;
  logic                rd_xfer;
  logic                rd_pop;
  logic                rd_en;
  logic [IDX_W-1:0]    rd_fetch_idx;
  logic [ADDR_W-1:0]   wr_addr;
  logic [ADDR_W-1:0]   rd_addr;

  assign wr_en   = (wr_state == WR_WRITE);
  assign wr_fin  = wr_en && (wr_idx == IDX_W'(N - 1));
  assign wr_addr = ADDR_W'(wr_ptr) * ADDR_W'(N) + ADDR_W'(wr_idx);

  // Next element is fetched in the cycle the current one transfers, so a held-ready stream has no bubbles.
  assign rd_xfer      = rd_valid && bus.i_rd_ready;
  assign rd_pop       = rd_xfer && rd_last;
  assign rd_en        = (rd_state == RD_FETCH) || (rd_xfer && !rd_last);
  assign rd_fetch_idx = (rd_state == RD_FETCH) ? '0 : rd_idx + IDX_W'(1);
  assign rd_addr      = ADDR_W'(rd_ptr) * ADDR_W'(N) + ADDR_W'(rd_fetch_idx);

  // Simple dual-port RAM; contents survive reset and ram_q only moves on a fetch, which gives the hold under stall.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem[wr_addr] <= shadow[DATA_W-1:0];
    end
    if (rd_en) begin
      ram_q <= mem[rd_addr];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_state <= WR_IDLE;
      shadow   <= '0;
      wr_idx   <= '0;
      wr_ptr   <= '0;
      busy     <= 1'b0;
      row_done <= 1'b0;
      overflow <= 1'b0;
    end else begin
      row_done <= 1'b0;
      case (wr_state)
        WR_IDLE: begin
          if (bus.i_valid) begin
            if (count < CNT_W'(ROWS)) begin
              shadow   <= bus.i_row;
              wr_idx   <= '0;
              busy     <= 1'b1;
              wr_state <= WR_WRITE;
            end else begin
              overflow <= 1'b1;
            end
          end
        end
        WR_WRITE: begin
          if (bus.i_valid) begin
            overflow <= 1'b1;
          end
          shadow <= shadow >> DATA_W;
          wr_idx <= wr_idx + IDX_W'(1);
          if (wr_fin) begin
            wr_state <= WR_IDLE;
            busy     <= 1'b0;
            row_done <= 1'b1;
            wr_ptr   <= (wr_ptr == PTR_W'(ROWS - 1)) ? '0 : wr_ptr + PTR_W'(1);
          end
        end
        default: wr_state <= WR_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_state <= RD_IDLE;
      rd_ptr   <= '0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      rd_idx   <= '0;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          if (bus.i_rd_start && (count != '0)) begin
            rd_state <= RD_FETCH;
          end
        end
        RD_FETCH: begin
          rd_state <= RD_STREAM;
          rd_valid <= 1'b1;
          rd_idx   <= '0;
          rd_last  <= 1'b0;
        end
        RD_STREAM: begin
          if (rd_xfer) begin
            if (rd_last) begin
              rd_valid <= 1'b0;
              rd_last  <= 1'b0;
              rd_state <= RD_IDLE;
              rd_ptr   <= (rd_ptr == PTR_W'(ROWS - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end else begin
              rd_idx  <= rd_idx + IDX_W'(1);
              rd_last <= (rd_idx == IDX_W'(N - 2));
            end
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

  // A completion and a pop on the same edge cancel, leaving the count unchanged.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(wr_fin) - CNT_W'(rd_pop);
    end
  end

  assign bus.o_busy        = busy;
  assign bus.o_row_done    = row_done;
  assign bus.o_rows_stored = count;
  assign bus.o_overflow    = overflow;
  assign bus.o_rd_valid    = rd_valid;
  // RAM output register has no reset; gating with valid keeps the data port at zero through reset and idle.
  assign bus.o_rd_data     = rd_valid ? ram_q : '0;
  assign bus.o_rd_idx      = rd_idx;
  assign bus.o_rd_last     = rd_last;
endmodule

// File: tb/tb_softmax_row_buffer.sv
// Bench for softmax_row_buffer: directed rows against a queue-based model plus literal latency/data pins.
module tb_softmax_row_buffer;
  localparam int N      = 32;
  localparam int DATA_W = 16;
  localparam int ROWS   = 4;

  typedef logic [N*DATA_W-1:0] row_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  softmax_row_buffer_if #(.N(N), .DATA_W(DATA_W), .ROWS(ROWS)) bus ();

  softmax_row_buffer #(.N(N), .DATA_W(DATA_W), .ROWS(ROWS)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic row_t make_row(input int base);
    row_t r;
    for (int k = 0; k < N; k++) r[k*DATA_W +: DATA_W] = DATA_W'(base + k);
    return r;
  endfunction

  // Model: accepted rows appear in the queue N+1 cycles after acceptance; reads stream the head row.
  row_t q[$];
  row_t wr_row;
  bit   wr_active, rd_active, m_done, m_ovf, m_vld;
  int   cyc, wr_done_cyc, rd_vld_cyc, beat;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      wr_active = 0; rd_active = 0; m_done = 0; m_ovf = 0; m_vld = 0;
      cyc = 0; beat = 0;
    end else begin
      bit acc_wr, acc_rd, xfer;
      acc_wr = bus.i_valid && !wr_active && (q.size() < ROWS);
      if (bus.i_valid && !acc_wr) m_ovf = 1;
      acc_rd = bus.i_rd_start && !rd_active && (q.size() > 0);
      xfer   = m_vld && bus.i_rd_ready;
      cyc++;
      m_done = 0;
      if (wr_active && cyc == wr_done_cyc) begin
        q.push_back(wr_row);
        wr_active = 0;
        m_done = 1;
      end
      if (acc_wr) begin
        wr_active = 1;
        wr_done_cyc = cyc + N;
        wr_row = bus.i_row;
      end
      if (xfer) begin
        if (beat == N - 1) begin
          void'(q.pop_front());
          rd_active = 0; m_vld = 0; beat = 0;
        end else begin
          beat++;
        end
      end
      if (rd_active && !m_vld && cyc == rd_vld_cyc) m_vld = 1;
      if (acc_rd) begin
        rd_active = 1;
        rd_vld_cyc = cyc + 1;
      end
    end
  end

  always @(negedge clk) begin
    check("busy",        64'(bus.o_busy),        64'(wr_active));
    check("row_done",    64'(bus.o_row_done),    64'(m_done));
    check("rows_stored", 64'(bus.o_rows_stored), 64'(q.size()));
    check("overflow",    64'(bus.o_overflow),    64'(m_ovf));
    check("rd_valid",    64'(bus.o_rd_valid),    64'(m_vld));
    if (m_vld && q.size() > 0) begin
      check("rd_data", 64'(bus.o_rd_data), 64'(q[0][beat*DATA_W +: DATA_W]));
      check("rd_idx",  64'(bus.o_rd_idx),  64'(beat));
      check("rd_last", 64'(bus.o_rd_last), 64'(beat == N - 1));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_row(input row_t r);
    bus.i_valid = 1'b1;
    bus.i_row   = r;
    tick();
    bus.i_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int g = 0;
    while (!bus.o_row_done && g < 100) begin tick(); g++; end
    check(name, 64'(g < 100), 64'(1));
    tick();
  endtask

  task automatic read_rows(input int nrows);
    bus.i_rd_ready = 1'b1;
    for (int r = 0; r < nrows; r++) begin
      int g = 0;
      bus.i_rd_start = 1'b1;
      tick();
      bus.i_rd_start = 1'b0;
      while (!(bus.o_rd_valid && bus.o_rd_last) && g < 100) begin tick(); g++; end
      check("read_row_end", 64'(g < 100), 64'(1));
      tick();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, beats, busy_n, got, done_cnt;
    bus.i_valid = 1'b0; bus.i_row = '0; bus.i_rd_start = 1'b0; bus.i_rd_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",    64'(bus.o_busy), 64'(0));
    check("rst_stored",  64'(bus.o_rows_stored), 64'(0));
    check("rst_rdvalid", 64'(bus.o_rd_valid), 64'(0));
    check("rst_ovf",     64'(bus.o_overflow), 64'(0));
    rst = 1'b0;
    tick();

    // Single row: latency, busy length, in-order streaming
    send_row(make_row(16'h0100));
    n = 1; busy_n = 0;
    while (!bus.o_row_done && n < 100) begin
      if (bus.o_busy) busy_n++;
      tick(); n++;
    end
    check("t1_done_lat", 64'(n), 64'(33));
    check("t1_busy_cycles", 64'(busy_n), 64'(32));
    check("t1_stored", 64'(bus.o_rows_stored), 64'(1));
    bus.i_rd_ready = 1'b1; bus.i_rd_start = 1'b1;
    tick();
    bus.i_rd_start = 1'b0;
    n = 1;
    while (!bus.o_rd_valid && n < 20) begin tick(); n++; end
    check("t1_rd_lat", 64'(n), 64'(2));
    beats = 0;
    while (bus.o_rd_valid && beats < 40) begin
      check("t1_data", 64'(bus.o_rd_data), 64'(16'h0100 + beats));
      check("t1_idx",  64'(bus.o_rd_idx), 64'(beats));
      check("t1_last", 64'(bus.o_rd_last), 64'(beats == 31));
      tick(); beats++;
    end
    check("t1_beats", 64'(beats), 64'(32));
    check("t1_stored_end", 64'(bus.o_rows_stored), 64'(0));

    // Read start with an empty buffer is ignored
    bus.i_rd_start = 1'b1;
    tick();
    bus.i_rd_start = 1'b0;
    n = 0;
    repeat (10) begin
      if (bus.o_rd_valid) n++;
      tick();
    end
    check("t7_no_valid", 64'(n), 64'(0));

    // Backpressure: ready high one cycle in three
    send_row(make_row(16'h0A00));
    wait_done("t3_done");
    bus.i_rd_ready = 1'b0; bus.i_rd_start = 1'b1;
    tick();
    bus.i_rd_start = 1'b0;
    got = 0; n = 0;
    while (got < N && n < 300) begin
      bus.i_rd_ready = (n % 3 == 0);
      if (bus.o_rd_valid && bus.i_rd_ready) begin
        check("t3_idx",  64'(bus.o_rd_idx), 64'(got));
        check("t3_data", 64'(bus.o_rd_data), 64'(16'h0A00 + got));
        got++;
      end
      tick(); n++;
    end
    check("t3_count", 64'(got), 64'(N));
    check("t3_valid_end", 64'(bus.o_rd_valid), 64'(0));
    bus.i_rd_ready = 1'b1;

    // Fill all slots, overflow on the fifth row, drain with pointer wrap
    for (int r = 0; r < ROWS; r++) begin
      send_row(make_row(r * 256));
      wait_done("t2_done");
    end
    check("t2_full", 64'(bus.o_rows_stored), 64'(4));
    send_row(make_row(16'h0F00));
    tick();
    check("t2_ovf", 64'(bus.o_overflow), 64'(1));
    check("t2_full_kept", 64'(bus.o_rows_stored), 64'(4));
    check("t2_not_busy", 64'(bus.o_busy), 64'(0));
    bus.i_rd_ready = 1'b1; bus.i_rd_start = 1'b1;
    tick();
    bus.i_rd_start = 1'b0;
    tick();
    check("t2_row0_first", 64'(bus.o_rd_data), 64'(16'h0000));
    while (bus.o_rd_valid) tick();
    read_rows(3);
    check("t2_empty", 64'(bus.o_rows_stored), 64'(0));

    // i_valid during a write: dropped, single row_done
    do_reset();
    check("t4_ovf_cleared", 64'(bus.o_overflow), 64'(0));
    send_row(make_row(16'h5500));
    repeat (9) tick();
    send_row(make_row(16'h6600));
    done_cnt = 0;
    repeat (60) begin
      if (bus.o_row_done) done_cnt++;
      tick();
    end
    check("t4_done_once", 64'(done_cnt), 64'(1));
    check("t4_ovf", 64'(bus.o_overflow), 64'(1));
    check("t4_stored", 64'(bus.o_rows_stored), 64'(1));
    read_rows(1);

    // Last pop and write completion on the same edge at count ROWS-1
    do_reset();
    for (int r = 0; r < ROWS - 1; r++) begin
      send_row(make_row(16'h7000 + r * 256));
      wait_done("t5_fill");
    end
    check("t5_pre", 64'(bus.o_rows_stored), 64'(3));
    bus.i_rd_ready = 1'b1; bus.i_rd_start = 1'b1;
    tick();
    bus.i_rd_start = 1'b0;
    send_row(make_row(16'h7300));
    n = 0;
    while (!bus.o_row_done && n < 100) begin tick(); n++; end
    check("t5_coincide_valid", 64'(bus.o_rd_valid), 64'(0));
    check("t5_count_same", 64'(bus.o_rows_stored), 64'(3));
    tick();
    check("t5_count_after", 64'(bus.o_rows_stored), 64'(3));
    read_rows(3);
    check("t5_empty", 64'(bus.o_rows_stored), 64'(0));

    // Reset mid-write and mid-stream
    send_row(make_row(16'h8000));
    repeat (5) tick();
    rst = 1'b1;
    #1;
    check("t6w_busy", 64'(bus.o_busy), 64'(0));
    check("t6w_stored", 64'(bus.o_rows_stored), 64'(0));
    tick();
    rst = 1'b0;
    repeat (40) tick();
    check("t6w_no_done_row", 64'(bus.o_rows_stored), 64'(0));
    send_row(make_row(16'h8100));
    wait_done("t6s_done");
    bus.i_rd_ready = 1'b1; bus.i_rd_start = 1'b1;
    tick();
    bus.i_rd_start = 1'b0;
    repeat (6) tick();
    rst = 1'b1;
    #1;
    check("t6s_valid", 64'(bus.o_rd_valid), 64'(0));
    check("t6s_data", 64'(bus.o_rd_data), 64'(0));
    check("t6s_stored", 64'(bus.o_rows_stored), 64'(0));
    tick();
    rst = 1'b0;
    tick();
    send_row(make_row(16'h8200));
    wait_done("t6f_done");
    bus.i_rd_start = 1'b1;
    tick();
    bus.i_rd_start = 1'b0;
    tick();
    check("t6f_first", 64'(bus.o_rd_data), 64'(16'h8200));
    while (bus.o_rd_valid) tick();
    check("t6f_empty", 64'(bus.o_rows_stored), 64'(0));
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
